// File: rtl/gpr_modport.sv
// General-purpose register file: two combinational read ports, one synchronous
// write port (active-low enable) with same-cycle write-to-read bypass.
module gpr_modport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_0,
  output logic [DATA_W-1:0] rd_data_0,
  input  logic [ADDR_W-1:0] rd_addr_1,
  output logic [DATA_W-1:0] rd_data_1,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_we_
);

  localparam logic [ADDR_W:0] NUM_REGS_W = NUM_REGS[ADDR_W:0];

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              wr_en;

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return ({1'b0, addr} < NUM_REGS_W);
  endfunction

  // An unknown enable leaves wr_en at its default, so X never reaches storage.
  always_comb begin
    wr_en = 1'b0;
    if (!rst && (wr_we_ == 1'b0) && in_range(wr_addr)) begin
      wr_en = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_en && (wr_addr == ADDR_W'(i))) begin
        regs_d[i] = wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] val;
    val = '0;
    if (wr_en && (addr == wr_addr)) begin
      val = wr_data;
    end else if (in_range(addr)) begin
      val = regs_q[addr];
    end
    return val;
  endfunction

  always_comb begin
    rd_data_0 = read_port(rd_addr_0);
    rd_data_1 = read_port(rd_addr_1);
  end

endmodule

// File: tb/tb_gpr_modport.sv
// Bench for gpr_modport: an array-based reference checked every cycle, plus
// directed vectors with literal expectations.
module tb_gpr_modport;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] rd_addr_0, rd_addr_1, wr_addr;
  logic [DATA_W-1:0] rd_data_0, rd_data_1, wr_data;
  logic              wr_we_;

  int vectors    = 0;
  int miscompares = 0;

  logic [DATA_W-1:0] model [NUM_REGS];
  logic              model_ok = 1'b0;

  gpr_modport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) dut (
    .clk      (clk),
    .rst      (rst),
    .rd_addr_0(rd_addr_0),
    .rd_data_0(rd_data_0),
    .rd_addr_1(rd_addr_1),
    .rd_data_1(rd_data_1),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_we_   (wr_we_)
  );

  always #5 clk = ~clk;

  // Reference storage: cleared on a reset edge, written on an enabled edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) model[i] <= '0;
      model_ok <= 1'b1;
    end else if (wr_we_ === 1'b0 && int'(wr_addr) < NUM_REGS) begin
      model[wr_addr] <= wr_data;
    end
  end

  function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] a);
    if (rst === 1'b0 && wr_we_ === 1'b0 && a == wr_addr && int'(wr_addr) < NUM_REGS)
      return wr_data;
    if (int'(a) < NUM_REGS)
      return model[a];
    return '0;
  endfunction

  always @(negedge clk) begin
    if (model_ok) begin
      vectors++;
      if (rd_data_0 !== model_read(rd_addr_0)) begin
        miscompares++;
        $display("FAIL model_rd0 addr=%0d: got %h want %h", rd_addr_0, rd_data_0, model_read(rd_addr_0));
      end
      vectors++;
      if (rd_data_1 !== model_read(rd_addr_1)) begin
        miscompares++;
        $display("FAIL model_rd1 addr=%0d: got %h want %h", rd_addr_1, rd_data_1, model_read(rd_addr_1));
      end
    end
  end

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DATA_W-1:0] v;
    rst = 1'b1; wr_we_ = 1'b1; wr_addr = '0; wr_data = '0;
    rd_addr_0 = '0; rd_addr_1 = '0;
    step();
    rst = 1'b0;

    // Post-reset sweep on both ports.
    for (int i = 0; i < NUM_REGS; i++) begin
      rd_addr_0 = ADDR_W'(i);
      rd_addr_1 = ADDR_W'(NUM_REGS - 1 - i);
      #2;
      check("reset_rd0", rd_data_0, 32'h0);
      check("reset_rd1", rd_data_1, 32'h0);
      step();
    end

    // Write then read.
    wr_addr = 5'd5; wr_data = 32'hDEADBEEF; wr_we_ = 1'b0;
    step();
    wr_we_ = 1'b1; rd_addr_0 = 5'd5; rd_addr_1 = 5'd6;
    #2;
    check("wr_rd_r5", rd_data_0, 32'hDEADBEEF);
    check("wr_rd_r6", rd_data_1, 32'h0);
    step();

    // Bypass over an older value.
    wr_addr = 5'd7; wr_data = 32'h11; wr_we_ = 1'b0;
    step();
    wr_data = 32'h22; rd_addr_0 = 5'd7; rd_addr_1 = 5'd7;
    #2;
    check("bypass_rd0", rd_data_0, 32'h22);
    check("bypass_rd1", rd_data_1, 32'h22);
    step();
    wr_we_ = 1'b1;
    #2;
    check("bypass_stored", rd_data_0, 32'h22);
    step();

    // Disabled write must neither store nor bypass.
    for (int k = 0; k < 3; k++) begin
      wr_we_ = 1'b1; wr_addr = 5'd3; wr_data = 32'h55; rd_addr_0 = 5'd3;
      #2;
      check("disabled_r3", rd_data_0, 32'h0);
      step();
    end

    // Reset priority over a concurrent write; r2 preloaded so the read is meaningful.
    wr_addr = 5'd2; wr_data = 32'h77; wr_we_ = 1'b0;
    step();
    rst = 1'b1; wr_data = 32'hAA; rd_addr_0 = 5'd2; rd_addr_1 = 5'd5;
    #2;
    check("rst_no_bypass_r2", rd_data_0, 32'h77);
    check("rst_stored_r5", rd_data_1, 32'hDEADBEEF);
    step();
    rst = 1'b0; wr_we_ = 1'b1;
    #2;
    check("rst_cleared_r2", rd_data_0, 32'h0);
    check("rst_cleared_r5", rd_data_1, 32'h0);
    step();

    // Full write sweep, then reverse read-back.
    for (int i = 0; i < NUM_REGS; i++) begin
      v = DATA_W'(i) * 32'h01010101;
      wr_addr = ADDR_W'(i); wr_data = v; wr_we_ = 1'b0; rd_addr_0 = ADDR_W'(i);
      #2;
      check("sweep_bypass", rd_data_0, v);
      step();
    end
    wr_we_ = 1'b1;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      rd_addr_0 = ADDR_W'(i);
      rd_addr_1 = ADDR_W'((i + 1) % NUM_REGS);
      #2;
      check("sweep_rd0", rd_data_0, DATA_W'(i) * 32'h01010101);
      check("sweep_rd1", rd_data_1, DATA_W'((i + 1) % NUM_REGS) * 32'h01010101);
      step();
    end
    rd_addr_0 = 5'd31; rd_addr_1 = 5'd30;
    #2;
    check("last_r31", rd_data_0, 32'h1F1F1F1F);
    check("r30", rd_data_1, 32'h1E1E1E1E);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
